// File: rtl/pll_ctrl.sv
// -----------------------------------------------------------------------------
// pll_ctrl -- PLL reset / lock supervisor
//
// Pulses the PLL reset, waits for lock, and requires a stable lock before it
// releases the reset of the logic clocked by the PLL. A lock timeout retries
// the PLL reset up to MAX_RETRY times before the block parks in FAIL. FAIL is
// left only by a retry_req pulse. Loss of lock while running restarts the
// sequence and is counted in a saturating counter.
//
// Ports:
//   sys_clk    in   system clock, all logic on its rising edge
//   sys_rst    in   synchronous active-high reset
//   locked     in   PLL lock indicator (asynchronous to sys_clk)
//   retry_req  in   single-cycle pulse, honoured only in FAIL
//   pll_areset out  reset to the PLL instance (active-high)
//   rst_out    out  reset for PLL-clocked logic (active-high)
//   lock_fail  out  high while in FAIL
//   state      out  current state code (0..4)
//   retry_cnt  out  retries used in the current attempt
//   lol_cnt    out  loss-of-lock events seen in RUN, saturating at 255
// -----------------------------------------------------------------------------
module pll_ctrl #(
  parameter int unsigned RST_HOLD_CYC = 10,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       locked,
  input  logic       retry_req,
  output logic       pll_areset,
  output logic       rst_out,
  output logic       lock_fail,
  output logic [2:0] state,
  output logic [1:0] retry_cnt,
  output logic [7:0] lol_cnt
);

  // Counter only ever reaches (largest count parameter - 1).
  localparam int unsigned CNT_MAX_AB = (RST_HOLD_CYC > LOCK_TIMEOUT) ? RST_HOLD_CYC : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX    = (CNT_MAX_AB > LOCK_STABLE) ? CNT_MAX_AB : LOCK_STABLE;
  localparam int          CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      retry_q, retry_d;
  logic [7:0]      lol_q, lol_d;
  logic            sync1_q, locked_s_q;
  logic            pll_areset_q, rst_out_q, lock_fail_q;

  // Next-state logic.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lol_d   = lol_q;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = S_STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = S_RESET_PLL;
          end
        end
      end
      S_STABILIZE: begin
        if (!locked_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        if (!locked_s_q) begin
          state_d = S_RESET_PLL;
          if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
        end
      end
      S_FAIL: begin
        if (retry_req) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = S_RESET_PLL;  // unused codes 5..7 recover
    endcase

    // Counter restarts on every state change; RUN and FAIL do not time anything.
    if ((state_d != state_q) || (state_q == S_RUN) || (state_q == S_FAIL)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order in the block.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      lol_q        <= '0;
      sync1_q      <= 1'b0;
      locked_s_q   <= 1'b0;
      pll_areset_q <= 1'b1;
      rst_out_q    <= 1'b1;
      lock_fail_q  <= 1'b0;
    end else begin
      // NOTE: two-flop synchronizer; only locked_s_q feeds decisions so a
      // metastable first stage never reaches the FSM.
      sync1_q      <= locked;
      locked_s_q   <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lol_q        <= lol_d;
      // Outputs decoded from the next state so they move on the same edge.
      pll_areset_q <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      rst_out_q    <= (state_d != S_RUN);
      lock_fail_q  <= (state_d == S_FAIL);
    end
  end

  assign state      = state_q;
  assign retry_cnt  = retry_q;
  assign lol_cnt    = lol_q;
  assign pll_areset = pll_areset_q;
  assign rst_out    = rst_out_q;
  assign lock_fail  = lock_fail_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_ctrl -- self-checking bench for pll_ctrl
//
// A table of {inputs, cycles, expected outputs} rows walks the nominal bring-up
// (reset hold, lock, stabilize, run, loss of lock). Hand-written sequences then
// cover lock timeout with retries into FAIL, a lock glitch during STABILIZE,
// lol_cnt saturation, and sys_rst in the middle of WAIT_LOCK, RUN and FAIL.
// LOCK_TIMEOUT is shortened to 100 cycles; other parameters use defaults.
// -----------------------------------------------------------------------------
module tb_pll_ctrl;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       locked;
  logic       retry_req;
  logic       pll_areset;
  logic       rst_out;
  logic       lock_fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] lol_cnt;

  int n_vec = 0;
  int n_err = 0;

  pll_ctrl #(
    .RST_HOLD_CYC(10),
    .LOCK_TIMEOUT(100),
    .LOCK_STABLE (16),
    .MAX_RETRY   (3)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .locked    (locked),
    .retry_req (retry_req),
    .pll_areset(pll_areset),
    .rst_out   (rst_out),
    .lock_fail (lock_fail),
    .state     (state),
    .retry_cnt (retry_cnt),
    .lol_cnt   (lol_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       lck;
    logic       rq;
    int         cyc;
    logic [2:0] st;
    logic       ar;
    logic       ro;
    logic       lf;
    logic [1:0] rc;
    logic [7:0] lol;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply n rising edges, then land on the following falling edge to sample.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic ar,
                           input logic ro, input logic lf, input logic [1:0] rc,
                           input logic [7:0] lol);
    check({tag, ".state"},      32'(state),      32'(st));
    check({tag, ".pll_areset"}, 32'(pll_areset), 32'(ar));
    check({tag, ".rst_out"},    32'(rst_out),    32'(ro));
    check({tag, ".lock_fail"},  32'(lock_fail),  32'(lf));
    check({tag, ".retry_cnt"},  32'(retry_cnt),  32'(rc));
    check({tag, ".lol_cnt"},    32'(lol_cnt),    32'(lol));
  endtask

  initial begin
    int run_len;
    int pulses;
    int exp_lol;

    //            rst   lck   rq   cyc  st    ar    ro    lf    rc    lol
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2,  3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0};  // in reset
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 9,  3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0};  // hold 9 of 10
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1,  3'd1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};  // 10th edge -> WAIT
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4,  3'd1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};  // still unlocked
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2,  3'd1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};  // sync in flight
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1,  3'd2, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};  // 3rd edge -> STAB
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 15, 3'd2, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};  // stabilizing
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1,  3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};  // 16th -> RUN
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1,  3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};  // retry_req ignored
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4,  3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2,  3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};  // drop in sync
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1,  3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1};  // loss of lock

    sys_rst   = 1'b1;
    locked    = 1'b0;
    retry_req = 1'b0;

    // ---- nominal bring-up from the table ----
    for (int i = 0; i < 12; i++) begin
      sys_rst   = vecs[i].rst;
      locked    = vecs[i].lck;
      retry_req = vecs[i].rq;
      step(vecs[i].cyc);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ar, vecs[i].ro,
                vecs[i].lf, vecs[i].rc, vecs[i].lol);
    end
    retry_req = 1'b0;

    // ---- lock never returns: initial pulse + 3 retries, then FAIL ----
    run_len = 0;
    pulses  = 0;
    for (int i = 0; i < 2000 && !lock_fail; i++) begin
      if (pll_areset) begin
        run_len++;
      end else begin
        if (run_len != 0) begin
          pulses++;
          check($sformatf("areset_pulse%0d_len", pulses), 32'(run_len), 32'd10);
        end
        run_len = 0;
      end
      step(1);
    end
    check("timeout_pulses", 32'(pulses), 32'd4);
    check_all("fail_entry", 3'd4, 1'b1, 1'b1, 1'b1, 2'd3, 8'd1);
    step(20);
    check_all("fail_hold", 3'd4, 1'b1, 1'b1, 1'b1, 2'd3, 8'd1);
    retry_req = 1'b1;
    locked    = 1'b1;
    step(1);
    retry_req = 1'b0;
    check_all("fail_retry", 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1);

    // ---- glitch low for 4 cycles at STABILIZE counter=8 ----
    for (int i = 0; i < 50 && state != 3'd2; i++) step(1);
    check("glitch_stab_entry", 32'(state), 32'd2);
    step(8);
    locked = 1'b0;
    step(2);
    check("glitch_still_stab", 32'(state), 32'd2);
    step(1);
    check_all("glitch_back_wait", 3'd1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1);
    step(1);
    locked = 1'b1;
    step(2);
    check("glitch_wait_hold", 32'(state), 32'd1);
    step(1);
    check("glitch_restab", 32'(state), 32'd2);
    step(15);
    check("glitch_rst_out_held", 32'(rst_out), 32'd1);
    step(1);
    check_all("glitch_run", 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);

    // ---- 256 losses of lock: lol_cnt saturates at 255 ----
    exp_lol = 1;
    for (int k = 0; k < 256; k++) begin
      locked = 1'b0;
      step(3);
      exp_lol = (exp_lol < 255) ? exp_lol + 1 : 255;
      check($sformatf("lol%0d_state", k), 32'(state), 32'd0);
      check($sformatf("lol%0d_cnt", k), 32'(lol_cnt), 32'(exp_lol));
      locked = 1'b1;
      for (int i = 0; i < 100 && state != 3'd3; i++) step(1);
      check($sformatf("lol%0d_relock", k), 32'(state), 32'd3);
    end
    check_all("lol_saturated", 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'd255);

    // ---- sys_rst in RUN, mid WAIT_LOCK (retry_cnt=1), and in FAIL ----
    sys_rst = 1'b1;
    step(1);
    check_all("rst_in_run", 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    sys_rst = 1'b0;
    locked  = 1'b0;
    step(10);
    check("rst_hold_then_wait", 32'(state), 32'd1);
    step(100);
    check_all("first_timeout", 3'd0, 1'b1, 1'b1, 1'b0, 2'd1, 8'd0);
    step(30);
    check_all("mid_wait", 3'd1, 1'b0, 1'b1, 1'b0, 2'd1, 8'd0);
    sys_rst   = 1'b1;
    retry_req = 1'b1;
    step(1);
    check_all("rst_in_wait", 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    sys_rst   = 1'b0;
    retry_req = 1'b0;
    for (int i = 0; i < 2000 && !lock_fail; i++) step(1);
    check("reach_fail_again", 32'(lock_fail), 32'd1);
    sys_rst = 1'b1;
    step(1);
    check_all("rst_in_fail", 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    sys_rst = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
